dm_responder: RTL and testbench

Synthesizable data-memory responder for the pipelined MIPS core's M-stage data bus (`m_data_addr`, `m_data_wdata`, `m_data_byteen`, `m_data_rdata`). It serves word reads combinationally, merges byte-enabled writes at the clock edge and clears its array after reset with a one-word-per-cycle sweep. It optionally emits a store-trace record stream (PC, word address, merged word) through a small FIFO toward a trace sink. It sits outside `mips` on the board/top level, in place of a behavioural memory model.

---
 rtl/dm_pkg.sv | 29 ++
 rtl/dm_if.sv | 37 +++
 rtl/dm_trace_fifo.sv | 52 +++++
 rtl/dm_responder.sv | 112 +++++++++++
 tb/tb_dm_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder and its store-trace FIFO.
package dm_pkg;

  localparam int DM_DEPTH_WORDS_DEFAULT = 4096;

  typedef enum logic {
    CLEAR,
    RUN
  } dm_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } dm_trace_rec_t;

  // Replace the byte lanes selected by byteen with the matching lanes of wdata.
  function automatic logic [31:0] dm_merge(input logic [31:0] old_w,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  byteen);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (byteen[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_if.sv
// M-stage data bus between core and data memory; trace signals exist only with DM_TRACE_EN.
interface dm_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        dm_busy;
`ifdef DM_TRACE_EN
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, dm_busy, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow
  );
  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, dm_busy, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow
  );
`else
  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  m_data_rdata, dm_busy
  );
  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output m_data_rdata, dm_busy
  );
`endif
endinterface

// File: rtl/dm_trace_fifo.sv
// Synchronous FIFO of store-trace records; a push is accepted when full if a pop happens in the same cycle.
module dm_trace_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  dm_trace_rec_t push_rec,
  output dm_trace_rec_t head_rec,
  output logic          valid,
  output logic          full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;
  dm_trace_rec_t    mem_q [DEPTH];

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != (PTR_W+1)'(DEPTH)) || do_pop);
    cnt_d   = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_rec;
  end

  assign valid    = (cnt_q != '0);
  assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
  // Storage is not reset, so the head is masked to keep idle outputs at zero.
  assign head_rec = valid ? mem_q[rd_q] : '0;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: combinational word reads, byte-merged writes, post-reset clear sweep.
// Optional store-trace FIFO enabled by defining DM_TRACE_EN.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS_DEFAULT,
  parameter int TRACE_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dm_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] idx, wr_idx;
  logic [31:0]      old_word, merged, wr_data;
  logic             wr_en, run_wr;

  assign idx      = bus.m_data_addr[IDX_W+1:2];
  assign old_word = mem_q[idx];
  assign merged   = dm_merge(old_word, bus.m_data_wdata, bus.m_data_byteen);

  // The sweep and bus writes share one write port; CLEAR owns it until the last word is zeroed.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = merged;
    run_wr  = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_en   = !reset;
        wr_idx  = ptr_q;
        wr_data = '0;
        ptr_d   = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH_WORDS - 1)) state_d = RUN;
      end
      RUN: begin
        run_wr = !reset && (bus.m_data_byteen != 4'b0000);
        wr_en  = run_wr;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign bus.dm_busy      = (state_q == CLEAR);
  assign bus.m_data_rdata = (state_q == RUN) ? old_word : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.m_data_addr[31:IDX_W+2], bus.m_data_addr[1:0]};

`ifdef DM_TRACE_EN
  dm_trace_rec_t push_rec, head_rec;
  logic          fifo_pop, fifo_valid, fifo_full;
  logic          ovf_q, ovf_d;

  always_comb begin
    push_rec      = '0;
    push_rec.pc   = bus.m_inst_addr;
    push_rec.addr = {bus.m_data_addr[31:2], 2'b00};
    push_rec.data = merged;
    fifo_pop      = fifo_valid && bus.trace_ready;
    // A record is lost only when the FIFO is full and nothing leaves this cycle.
    ovf_d         = ovf_q || (run_wr && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  dm_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (run_wr),
    .pop      (fifo_pop),
    .push_rec (push_rec),
    .head_rec (head_rec),
    .valid    (fifo_valid),
    .full     (fifo_full)
  );

  assign bus.trace_valid    = fifo_valid;
  assign bus.trace_pc       = head_rec.pc;
  assign bus.trace_addr     = head_rec.addr;
  assign bus.trace_data     = head_rec.data;
  assign bus.trace_overflow = ovf_q;
`else
  logic unused_trace_pc;
  assign unused_trace_pc = ^bus.m_inst_addr;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Randomized scoreboard bench for dm_responder; trace checks are compiled in when DM_TRACE_EN is defined.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int DEPTH = 4096;
  localparam int TDEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_if bus();

  dm_responder #(.DEPTH_WORDS(DEPTH), .TRACE_DEPTH(TDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        busy;
    logic        tvalid;
    logic        tovf;
  } exp_t;

  exp_t          exp_q[$];
  dm_trace_rec_t tr_q[$];
  logic [31:0]   mdl_mem [DEPTH];
  int            left = DEPTH;
  int            cnt  = 0;
  logic          ovf  = 1'b0;
  logic          chk_rd = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, record expectations, advance the edge, update the reference model.
  task automatic step(input logic rst, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] pc, input logic rdy,
                      input logic chk);
    exp_t          e;
    int            ix;
    logic [31:0]   m;
    logic          pop;
    dm_trace_rec_t r;
    reset             = rst;
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = wdata;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
`ifdef DM_TRACE_EN
    bus.trace_ready   = rdy;
`endif
    ix = int'(addr[13:2]);
    if (chk) begin
      e.busy   = (left > 0);
      e.rdata  = (left > 0) ? 32'h0 : mdl_mem[ix];
      e.tvalid = (cnt > 0);
      e.tovf   = ovf;
      exp_q.push_back(e);
    end
    chk_rd = chk;
    @(posedge clk);
    #1;
    chk_rd = 1'b0;
    if (rst) begin
      left = DEPTH;
      cnt  = 0;
      ovf  = 1'b0;
      tr_q.delete();
    end else if (left > 0) begin
      left--;
      if (left == 0) foreach (mdl_mem[i]) mdl_mem[i] = 32'h0;
    end else begin
      pop = rdy && (cnt > 0);
      if (pop) cnt--;
      if (be != 4'b0000) begin
        m = mdl_mem[ix];
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wdata[8*b +: 8];
        mdl_mem[ix] = m;
        if (cnt < TDEPTH) begin
          r.pc   = pc;
          r.addr = addr & 32'hFFFF_FFFC;
          r.data = m;
          tr_q.push_back(r);
          cnt++;
        end else begin
          ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic peek(input logic [31:0] a, input string nm, input logic [31:0] ex);
    bus.m_data_addr   = a;
    bus.m_data_byteen = 4'b0000;
    #1;
    check(nm, bus.m_data_rdata, ex);
  endtask

  task automatic drain(output int n);
    n = 0;
`ifdef DM_TRACE_EN
    for (int k = 0; k < 10; k++) begin
      if (bus.trace_valid !== 1'b1) break;
      step(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
      n++;
    end
`endif
  endtask

  task automatic sweep(input string nm);
    int n;
    logic [31:0] a;
    n = 0;
    while (n < DEPTH + 500) begin
      a = $urandom & 32'h0000_00FC;
      step(1'b0, a, $urandom | 32'h1, 4'b1111, 32'h5000, 1'b1, 1'b1);
      n++;
      if (bus.dm_busy !== 1'b1) break;
    end
    check(nm, n, DEPTH);
  endtask

  // Monitor: compares every checked cycle and every trace handshake against the scoreboard.
  always @(negedge clk) begin
    exp_t          e;
    dm_trace_rec_t r;
    if (chk_rd && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rdata", bus.m_data_rdata, e.rdata);
      check("dm_busy", {31'b0, bus.dm_busy}, {31'b0, e.busy});
`ifdef DM_TRACE_EN
      check("trace_valid", {31'b0, bus.trace_valid}, {31'b0, e.tvalid});
      check("trace_overflow", {31'b0, bus.trace_overflow}, {31'b0, e.tovf});
      if (!e.tvalid) check("trace_idle_data", bus.trace_data, 32'h0);
`endif
    end
`ifdef DM_TRACE_EN
    if (bus.trace_valid === 1'b1 && bus.trace_ready === 1'b1) begin
      check("trace_expected", tr_q.size(), 1 + (tr_q.size() > 0 ? tr_q.size() - 1 : 0));
      if (tr_q.size() > 0) begin
        r = tr_q.pop_front();
        check("trace_pc", bus.trace_pc, r.pc);
        check("trace_addr", bus.trace_addr, r.addr);
        check("trace_data", bus.trace_data, r.data);
      end
    end
`endif
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd [5];
    logic [3:0]  be;
    int          n;

    reset             = 1'b1;
    bus.m_data_addr   = '0;
    bus.m_data_wdata  = '0;
    bus.m_data_byteen = '0;
    bus.m_inst_addr   = '0;
`ifdef DM_TRACE_EN
    bus.trace_ready   = 1'b0;
`endif

    // Three reset cycles; outputs are defined once the first reset edge has passed.
    step(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);

    // Start a sweep with writes presented, then reset at sweep cycle 100.
    for (int i = 0; i < 100; i++)
      step(1'b0, $urandom & 32'h0000_00FC, $urandom | 32'h1, 4'b1111, 32'h4000, 1'b0, 1'b1);
    step(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
    sweep("busy_cycles_after_midsweep_reset");

    peek(32'h0000_0000, "clear_read_0x0", 32'h0);
    peek(32'h0000_3FFC, "clear_read_0x3ffc", 32'h0);
    peek(32'h0000_8000, "clear_read_0x8000", 32'h0);
    for (int i = 0; i < 64; i++)
      step(1'b0, 32'(i) << 2, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);
      peek(32'(i * 4), "sweep_write_absent", 32'h0);
    end

    // Full-word write, then a single-lane write to the same word.
    step(1'b0, 32'h10, 32'h1234_5678, 4'b1111, 32'h3004, 1'b0, 1'b1);
    peek(32'h10, "full_word_read", 32'h1234_5678);
`ifdef DM_TRACE_EN
    check("w1_trace_valid", {31'b0, bus.trace_valid}, 32'h1);
    check("w1_trace_pc", bus.trace_pc, 32'h3004);
    check("w1_trace_addr", bus.trace_addr, 32'h10);
    check("w1_trace_data", bus.trace_data, 32'h1234_5678);
`endif
    step(1'b0, 32'h13, 32'h0000_AB00, 4'b0010, 32'h3008, 1'b0, 1'b1);
    peek(32'h10, "partial_read", 32'h1234_AB78);
    step(1'b0, 32'h14, 32'h1111_1111, 4'b1111, 32'h300C, 1'b0, 1'b1);
    step(1'b0, 32'h18, 32'h2222_2222, 4'b1111, 32'h3010, 1'b0, 1'b1);
    // FIFO holds four; push and pop together must not drop.
    step(1'b0, 32'h1C, 32'h3333_3333, 4'b1111, 32'h3014, 1'b1, 1'b1);
`ifdef DM_TRACE_EN
    check("simul_overflow", {31'b0, bus.trace_overflow}, 32'h0);
`endif
    drain(n);
`ifdef DM_TRACE_EN
    check("simul_held_count", n, 4);
`endif

    // Back-pressure: five writes with the sink stalled.
    for (int i = 0; i < 5; i++) begin
      wd[i] = $urandom;
      step(1'b0, 32'h40 + 32'(i * 4), wd[i], 4'b1111, 32'h3100 + 32'(i * 4), 1'b0, 1'b1);
    end
`ifdef DM_TRACE_EN
    check("bp_overflow", {31'b0, bus.trace_overflow}, 32'h1);
`endif
    for (int i = 0; i < 5; i++) begin
      peek(32'h40 + 32'(i * 4), "bp_mem_write", wd[i]);
      step(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);
    end
    drain(n);
`ifdef DM_TRACE_EN
    check("bp_drained_count", n, 4);
`endif

    // Random traffic with random sink stalls.
    for (int i = 0; i < 2000; i++) begin
      a  = $urandom & 32'hF000_007F;
      be = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      step(1'b0, a, $urandom, be, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) != 0), 1'b1);
    end

    // Reset mid-run: FIFO and overflow discarded, full sweep again.
    step(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h14, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b0, 1'b1);
`ifdef DM_TRACE_EN
    check("midrun_reset_valid", {31'b0, bus.trace_valid}, 32'h0);
    check("midrun_reset_overflow", {31'b0, bus.trace_overflow}, 32'h0);
`endif
    sweep("busy_cycles_after_midrun_reset");
    for (int i = 0; i < 32; i++)
      step(1'b0, 32'(i) << 2, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1);

    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
